// File: rtl/led_sequencer_if.sv
// Byte command channel into the LED sequencer.
// Valid/ready handshake; a byte moves when both are high on a rising edge.
interface led_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/led_sequencer.sv
// Two-byte command decoder driving static, blink and chase LED patterns.
// A prescaled tick feeds a period counter that advances the pattern.
module led_sequencer #(
  parameter int PRESCALE    = 50000,
  parameter int ARG_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  led_sequencer_if.slave cmd,
  output logic [7:0]     led,
  output logic           cmd_err
);

  localparam int PW = $clog2(PRESCALE);
  localparam int TW = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ARG_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARG   = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  // Encoding matches the low opcode bits of the mode commands.
  typedef enum logic [1:0] {
    M_STATIC = 2'd1,
    M_BLINK  = 2'd2,
    M_CHASE  = 2'd3
  } mode_e;

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [7:0]     op_q, op_d;
  logic [7:0]     arg_q, arg_d;
  logic [7:0]     pat_q, pat_d;
  logic [7:0]     period_q, period_d;
  logic [7:0]     led_q, led_d;
  logic [7:0]     scnt_q, scnt_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic           phase_q, phase_d;

  logic           ready;
  logic           xfer;
  logic           tick;
  logic           step;
  logic [7:0]     step_last;
  logic           op_mode;
  logic           op_period;
  logic           err;

  assign cmd.cmd_ready = ready;
  assign led           = led_q;
  assign cmd_err       = err;

  // Command FSM, time base and LED pattern update.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    op_d     = op_q;
    arg_d    = arg_q;
    pat_d    = pat_q;
    period_d = period_q;
    led_d    = led_q;
    phase_d  = phase_q;
    tcnt_d   = tcnt_q;
    err      = 1'b0;

    ready = (state_q != S_APPLY);
    xfer  = cmd.cmd_valid & ready;

    tick    = (presc_q == PRE_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);

    step_last = (period_q == 8'd0) ? 8'd0 : period_q - 8'd1;
    step      = tick && (scnt_q == step_last);
    scnt_d    = scnt_q;
    if (tick) begin
      scnt_d = step ? 8'd0 : scnt_q + 8'd1;
    end

    op_mode   = (op_q == 8'h01) || (op_q == 8'h02) ||
                (op_q == 8'h03);
    op_period = (op_q == 8'h04);

    // Pattern advance; APPLY owns the LED register that cycle.
    if (step && state_q != S_APPLY) begin
      case (mode_q)
        M_BLINK: begin
          phase_d = ~phase_q;
          led_d   = phase_q ? 8'h00 : pat_q;
        end
        M_CHASE: led_d = {led_q[6:0], led_q[7]};
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          op_d    = cmd.cmd_data;
          tcnt_d  = '0;
          state_d = S_ARG;
        end
      end
      S_ARG: begin
        if (xfer) begin
          arg_d   = cmd.cmd_data;
          state_d = S_APPLY;
        end else if (tick) begin
          if (tcnt_q == TO_LAST) begin
            err     = 1'b1;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_APPLY: begin
        state_d = S_IDLE;
        unique case (1'b1)
          op_mode: begin
            mode_d  = mode_e'(op_q[1:0]);
            pat_d   = arg_q;
            led_d   = arg_q;
            presc_d = '0;
            scnt_d  = 8'd0;
            phase_d = 1'b1;
          end
          op_period: begin
            period_d = arg_q;
            scnt_d   = 8'd0;
          end
          default: err = 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= M_STATIC;
      op_q     <= 8'h00;
      arg_q    <= 8'h00;
      pat_q    <= 8'h00;
      period_q <= 8'd100;
      led_q    <= 8'h00;
      scnt_q   <= 8'd0;
      presc_q  <= '0;
      tcnt_q   <= '0;
      phase_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      pat_q    <= pat_d;
      period_q <= period_d;
      led_q    <= led_d;
      scnt_q   <= scnt_d;
      presc_q  <= presc_d;
      tcnt_q   <= tcnt_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Command-driven controller for the eight onboard LEDs. It accepts a byte stream (typically the serial RX path from the AVR) through a valid/ready handshake and decodes two-byte commands. Each command configures a static, blink or chase pattern and the step period. It then sequences the LED register autonomously from a prescaled time base. It sits between the serial receiver and the `led` output pins in the top level.

## Interface
Parameters:
- `PRESCALE`, default 50000: clk cycles per tick (1 ms at 50 MHz); must be ≥ 2.
- `ARG_TIMEOUT`, default 255: ticks to wait for an argument byte before abandoning a command.

Ports:
- `clk`, in, 1: system clock (50 MHz); all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_data`, in, 8: command byte.
- `cmd_valid`, in, 1: `cmd_data` is valid.
- `cmd_ready`, out, 1: block can accept a byte. A byte transfers on an edge where `cmd_valid & cmd_ready`.
- `led`, out, 8: LED drive, registered.
- `cmd_err`, out, 1: one-cycle pulse on an unknown opcode or an argument timeout.

## Operation
Command framing:
- Byte 1 is the opcode; byte 2 is the argument `arg`.
- 0x01 STATIC: mode=STATIC, pattern=`arg`.
- 0x02 BLINK: mode=BLINK, pattern=`arg`.
- 0x03 CHASE: mode=CHASE, pattern=`arg`.
- 0x04 PERIOD: period=`arg`. Mode, pattern and `led` are unchanged.
- Any other opcode still consumes its argument byte, so framing is preserved. It causes no state change and pulses `cmd_err` in the APPLY cycle.

FSM (`cmd_ready` per state):
- IDLE (`cmd_ready`=1): on byte transfer, latch the opcode and go to ARG.
- ARG (`cmd_ready`=1):
  - On byte transfer, latch `arg` and go to APPLY.
  - On timeout, pulse `cmd_err`, discard the opcode and go to IDLE.
  - The timeout counter clears on entry to ARG and increments per tick. Timeout occurs on the tick that brings the count to `ARG_TIMEOUT`.
  - If a byte transfer and timeout occur on the same edge, the byte wins.
- APPLY (`cmd_ready`=0, exactly one cycle): update the registers, then go to IDLE.

Applying a mode command (0x01–0x03):
- Set `led` to `pattern`.
- Clear the prescaler and step counter.
- Set the blink phase to ON.

Applying PERIOD clears only the step counter.

Time base:
- The prescaler counts 0..`PRESCALE`-1 and asserts `tick` when at `PRESCALE`-1, then wraps to 0.
- The step counter counts ticks 0..P-1, where P = period, except period 0 is treated as P=1.
- `step` is asserted on the tick where the count equals P-1, and the counter then wraps.

On `step`:
- STATIC: no change.
- BLINK: toggle the phase. `led` = pattern when ON, 0x00 when OFF.
- CHASE: `led` = {`led`[6:0], `led`[7]} (rotate left).

Reset values:
- `led`=0x00, `cmd_ready`=1 (state IDLE), `cmd_err`=0.
- mode=STATIC, pattern=0x00, period=100, phase=ON.
- All counters 0.
- `rst` mid-command discards any partial command.

## Timing
- Argument byte accepted at edge N: `led` and mode take their new values at edge N+1 (APPLY). `cmd_ready` is low in the N→N+1 cycle and high again after N+1.
- Back-to-back commands: at most one byte per cycle, one idle cycle per command. The sustained rate is 2 bytes per 3 cycles.
- With P = max(period, 1), successive `led` changes in BLINK or CHASE occur exactly P×`PRESCALE` cycles apart.
- The first change after a mode command occurs P×`PRESCALE` cycles after the APPLY edge.
- `cmd_err` is high for exactly one cycle: the APPLY cycle for an unknown opcode, or the timeout cycle.
- A period change takes effect on the next step boundary and re-times from the PERIOD APPLY edge.

## Test plan
Use `PRESCALE`=4 and `ARG_TIMEOUT`=3 throughout.
- **Reset:** assert `rst` for 2 cycles → `led`=0x00, `cmd_ready`=1, `cmd_err`=0. With no commands, `led` stays 0x00 for 2000 cycles.
- **STATIC:** send 0x01,0xA5 → `led`=0xA5 one edge after the argument transfer. `cmd_ready` is low exactly that one cycle.
- **BLINK with PERIOD:** send 0x04,0x02 then 0x02,0x0F → `led` goes 0x0F, then alternates 0x00/0x0F every 8 cycles.
- **CHASE with period 0:** send 0x04,0x00 then 0x03,0x81 → `led` steps 0x81, 0x03, 0x06, 0x0C every 4 cycles and wraps after 8 steps.
- **Errors:**
  - Send 0x07,0x55 → one-cycle `cmd_err`; `led` and mode unchanged.
  - Send 0x01 then hold `cmd_valid` low → `cmd_err` pulses 12 cycles after ARG entry and the FSM returns to IDLE. A following 0x01,0x3C then yields `led`=0x3C.
- **Reset mid-command:** send 0x02 only, pulse `rst`, then send 0x01,0xFF → `led`=0xFF. There is no framing slip and no `cmd_err`.
